// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared constants and FSM state encoding for the bit-serial
//               arithmetic blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    // Default operand/result width of the serial arithmetic blocks
    localparam int SUB_WIDTH_DEFAULT = 8;

    // Sequencer states shared by the bit-serial arithmetic blocks
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Bit-counter width: ceil(log2(w)), never less than one bit
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit combinational full subtractor (x - y - bw).
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bw,
    output logic d,
    output logic bo
);

    // A borrow is generated when y exceeds x, or propagated when x == y
    assign d  = x ^ y ^ bw;
    assign bo = (~x & y) | (~(x ^ y) & bw);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, LSB first, one bit per clock.
//               diff = (a - b - bin) mod 2^WIDTH, bout = borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int                 c_cnt_w = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    sub_state_t         r_state;
    sub_state_t         w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic [c_cnt_w-1:0] r_count;
    logic               r_borrow;
    logic               w_d;
    logic               w_bo;

    // Per-bit arithmetic on the currently selected operand bit
    full_subtractor u_full_subtractor (
        .x  (r_a[r_count]),
        .y  (r_b[r_count]),
        .bw (r_borrow),
        .d  (w_d),
        .bo (w_bo)
    );

    // State register; reset aborts any operation without a done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: accept in IDLE, leave BUSY after the MSB
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = BUSY;
            BUSY:    if (r_count == c_last) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: latch operands on accept, then retire one bit per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_count  <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_count  <= '0;
                    end
                end
                BUSY: begin
                    r_diff[r_count] <= w_d;
                    r_borrow        <= w_bo;
                    // Counter parks on the last index instead of wrapping
                    if (r_count != c_last) begin
                        r_count <= r_count + c_cnt_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status strobes come straight from the state register
    assign ready = (r_state == IDLE);
    assign busy  = (r_state != IDLE);
    assign done  = (r_state == DONE);
    assign diff  = r_diff;
    // After the last bit the borrow register holds the final borrow-out
    assign bout  = r_borrow;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin one subtraction.
REQ-005 SHALL have port a, input, WIDTH bits: minuend.
REQ-006 SHALL have port b, input, WIDTH bits: subtrahend.
REQ-007 SHALL have port bin, input, 1 bit: borrow-in, for chaining.
REQ-008 SHALL have port ready, output, 1 bit: high when idle and able to accept start.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress or completing.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port diff, output, WIDTH bits: result, equal to (a - b - bin) mod 2^WIDTH.
REQ-012 SHALL have port bout, output, 1 bit: borrow-out, 1 iff a < b + bin (unsigned).

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL make ready = (state==IDLE) and busy = (state!=IDLE), both decoded from state only.
REQ-015 SHALL, on a rising edge in IDLE with start=1, latch a, b and bin into internal registers, clear the bit counter and enter BUSY.
REQ-016 SHALL ignore start in BUSY and DONE, leaving the latched operands unaffected; changes on a, b or bin after acceptance SHALL have no effect on the result.
REQ-017 SHALL, in BUSY, process exactly one bit per cycle, LSB first, where bit i uses latched a[i], b[i] and the running borrow; borrow is initialised from the latched bin.
REQ-018 SHALL compute, per bit, d = x ^ y ^ bw and borrow_next = (~x & y) | (~(x ^ y) & bw).
REQ-019 SHALL write d into diff[i] and update the borrow register on the same edge.
REQ-020 SHALL transition BUSY->DONE on the edge that processes bit WIDTH-1, and DONE->IDLE on the following edge.
REQ-021 SHALL make done = (state==DONE), giving exactly one cycle high, WIDTH cycles after the start-acceptance edge.
REQ-022 SHALL make the final diff and bout valid no later than the cycle done is high, and hold them stable until the next accepted start.
REQ-023 SHALL leave intermediate diff bits undefined-to-consumer while busy=1; only values qualified by done or ready are contractual.
REQ-024 SHALL wrap silently modulo 2^WIDTH; no overflow flag other than bout.
REQ-025 SHALL, for WIDTH=1, spend exactly one cycle in BUSY.
REQ-026 SHALL size the bit counter as ceil(log2(WIDTH)), minimum 1 bit, with no wrap beyond WIDTH-1.

Reset
REQ-027 SHALL, while rst=1, immediately force state=IDLE, counter=0, borrow=0, diff=0 and bout=0, giving ready=1, busy=0 and done=0.
REQ-028 SHALL, on reset mid-operation, abort the operation with no done pulse; the first edge after rst deasserts SHALL behave as IDLE.

Structure
REQ-029 SHALL place the FSM state encoding and the WIDTH default constant in the shared package used by the arithmetic blocks.
REQ-030 SHALL instantiate per-bit logic as one sub-module, full_subtractor (inputs x, y, bw; outputs d, bo; purely combinational), reusable by other arithmetic blocks.

Verification
REQ-031 SHALL cover, with WIDTH=8: a=0x5A, b=0x3C, bin=0 -> done 8 cycles after accept, diff=0x1E, bout=0.
REQ-032 SHALL cover: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
REQ-033 SHALL cover: a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0; and a=0x0F, b=0x0F, bin=1 -> diff=0xFF, bout=1.
REQ-034 SHALL cover start held high continuously with operands changed during BUSY -> first result is unchanged; exactly one done per accept; next accept occurs on the IDLE cycle after DONE.
REQ-035 SHALL cover rst asserted asynchronously at bit 4 -> outputs cleared immediately; no done; a fresh operation after release is correct.
REQ-036 SHALL cover, with WIDTH=1: a=0, b=1, bin=0 -> done 1 cycle after accept, diff=1, bout=1.
